ram_fifo: RTL and testbench
===========================

# ram_fifo

Line-buffer FIFO sitting between the input controller and the bilinear calculation core of the scaler. It stores incoming pixel lines written by the input controller and serves four simultaneous pixel reads (a 2×2 neighbourhood from two adjacent lines) to the calculation core. It reports how many complete lines are buffered (`fifoNum`) and retires lines on the core's `jmp1`/`jmp2` requests.

## Interface
- `DATA_WIDTH`, 16, pixel width (RGB565)
- `ADDRESS_WIDTH`, 11, column address width; line length 2^ADDRESS_WIDTH words
- `BUFFER_SIZE`, 2, width of `fifoNum`; physical slots `SLOTS` = 2^BUFFER_SIZE, committed capacity `SLOTS-1`

- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `clr`  in  1  synchronous frame flush (pointers/count only)
- `dIn`  in  DATA_WIDTH  pixel from input controller
- `dInEn`  in  1  write strobe for `dIn`
- `ramAddrIn`  in  ADDRESS_WIDTH  column write address
- `lineEnd`  in  1  one-cycle pulse: line currently being written is complete
- `ramRdAddr00`, `ramRdAddr01`  in  ADDRESS_WIDTH  columns read from top line
- `ramRdAddr10`, `ramRdAddr11`  in  ADDRESS_WIDTH  columns read from bottom line
- `jmp1`  in  1  retire one line
- `jmp2`  in  1  retire two lines
- `ramData00`, `ramData01`, `ramData10`, `ramData11`  out  DATA_WIDTH  read data
- `fifoNum`  out  BUFFER_SIZE  committed lines available (0..SLOTS-1)
- `full`  out  1  `fifoNum == SLOTS-1`
- `ovf`  out  1  sticky overflow flag

## Operation
- State: `wrPtr`, `rdPtr` (BUFFER_SIZE bits, wrap modulo SLOTS), `cnt` (= `fifoNum`).
- Write: `dInEn` writes `dIn` at (`wrPtr`, `ramAddrIn`). Writes never target a committed slot.
- Commit: `lineEnd` with `cnt < SLOTS-1` → `wrPtr+1`, `cnt+1`. With `cnt == SLOTS-1` → line dropped, `wrPtr` unchanged, `ovf` set (sticky until `rst`/`clr`).
- Retire: `k` = 2 if `jmp2`, else 1 if `jmp1`, else 0 (`jmp2` wins when both high). Actual pop `p = min(k, cnt)`; `rdPtr += p`.
- Simultaneous commit and retire: `cnt_next = cnt + commit − p`, `p` computed from current `cnt`.
- Read slot select: top = `rdPtr`; bottom = `rdPtr+1` if `cnt >= 2`, else `rdPtr` (last-line edge replication).
- `cnt == 0`: reads return stale slot contents; core must not consume them.
- `clr`: `wrPtr`, `rdPtr`, `cnt`, `ovf` ← 0; memory contents untouched; overrides same-cycle `lineEnd`/`jmp*`.
- Arithmetic: pointer adds wrap naturally in BUFFER_SIZE bits; `cnt` never wraps.

## Timing
- Reset values: all `ramData*` = 0, `fifoNum` = 0, `full` = 0, `ovf` = 0; pointers 0.
- Read latency 1 cycle: address and slot select sampled at edge N, data valid after edge N (registered outputs).
- A `jmp*` at edge N changes slot select for addresses sampled at edge N+1 onward.
- `fifoNum`, `full` registered; update one cycle after `lineEnd`/`jmp*`.
- Write-then-read of the same word after commit: commit at edge N, earliest correct read address at edge N+1.
- `rst` mid-line discards the partial line.

## Structure
- Shared package `scaler_pkg`: `DATA_WIDTH`, `ADDRESS_WIDTH`, `BUFFER_SIZE`, `SLOTS`, pixel typedef.
- Sub-module `line_ram`: one line, one write port, two synchronous read ports; SLOTS instances. Top-level holds pointers, counter, per-port slot muxes.

## Test plan
- Reset: hold `rst` 2 cycles → all outputs 0; `fifoNum`=0.
- Write line A (pixel = column), `lineEnd`; line B (pixel = 0x100+column), `lineEnd` → `fifoNum`=2; addresses 00=3, 01=4, 10=3, 11=4 → next cycle data 3, 4, 0x103, 0x104.
- Only line A committed (`fifoNum`=1), read 10=5 → `ramData10`=5 (replication).
- Commit 3 lines, 4th `lineEnd` → `fifoNum` stays 3, `full`=1, `ovf`=1; `jmp1` → `fifoNum`=2, `full`=0, `ovf` still 1.
- `fifoNum`=2, `lineEnd` and `jmp2` same cycle → `fifoNum`=1, top slot = third line; `jmp1`+`jmp2` together with `fifoNum`=3 → `fifoNum`=1.
- `fifoNum`=1, `jmp2` → `fifoNum`=0 (saturate); then `clr` with pending `lineEnd` → `fifoNum`=0, `ovf`=0.

Source files
------------

// File: rtl/scaler_pkg.sv
// Shared scaler constants and types.
// Pixel, column and slot widths used by the line-buffer FIFO.
package scaler_pkg;

   localparam int DATA_WIDTH    = 16;
   localparam int ADDRESS_WIDTH = 11;
   localparam int BUFFER_SIZE   = 2;
   localparam int SLOTS         = 1 << BUFFER_SIZE;
   localparam int LINE_LEN      = 1 << ADDRESS_WIDTH;

   typedef logic [DATA_WIDTH-1:0]    pixel_t;
   typedef logic [ADDRESS_WIDTH-1:0] col_t;
   typedef logic [BUFFER_SIZE-1:0]   slot_t;

endpackage

// File: rtl/line_ram.sv
// One pixel line: one write port, two registered read ports.
// Ports: clk, rst (clears read regs), we/wr_addr/wr_data, rd_addr_a/b -> rd_data_a/b.
module line_ram
   import scaler_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   we,
   input  col_t   wr_addr,
   input  pixel_t wr_data,
   input  col_t   rd_addr_a,
   input  col_t   rd_addr_b,
   output pixel_t rd_data_a,
   output pixel_t rd_data_b
);

   pixel_t mem [LINE_LEN];

   pixel_t rd_a_q;
   pixel_t rd_a_d;
   pixel_t rd_b_q;
   pixel_t rd_b_d;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_a_d = mem[rd_addr_a];
      rd_b_d = mem[rd_addr_b];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_a_q <= '0;
         rd_b_q <= '0;
      end else begin
         rd_a_q <= rd_a_d;
         rd_b_q <= rd_b_d;
      end
   end

   assign rd_data_a = rd_a_q;
   assign rd_data_b = rd_b_q;

endmodule

// File: rtl/ram_fifo.sv
// Line-buffer FIFO feeding a 2x2 pixel neighbourhood to the bilinear core.
// Ports: clk/rst/clr, write side (dIn, dInEn, ramAddrIn, lineEnd),
// read side (ramRdAddr00..11 -> ramData00..11), retire (jmp1/jmp2),
// status (fifoNum, full, ovf).
module ram_fifo
   import scaler_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic [DATA_WIDTH-1:0]    dIn,
   input  logic                     dInEn,
   input  logic [ADDRESS_WIDTH-1:0] ramAddrIn,
   input  logic                     lineEnd,
   input  logic [ADDRESS_WIDTH-1:0] ramRdAddr00,
   input  logic [ADDRESS_WIDTH-1:0] ramRdAddr01,
   input  logic [ADDRESS_WIDTH-1:0] ramRdAddr10,
   input  logic [ADDRESS_WIDTH-1:0] ramRdAddr11,
   input  logic                     jmp1,
   input  logic                     jmp2,
   output logic [DATA_WIDTH-1:0]    ramData00,
   output logic [DATA_WIDTH-1:0]    ramData01,
   output logic [DATA_WIDTH-1:0]    ramData10,
   output logic [DATA_WIDTH-1:0]    ramData11,
   output logic [BUFFER_SIZE-1:0]   fifoNum,
   output logic                     full,
   output logic                     ovf
);

   localparam slot_t FULL_CNT = slot_t'(SLOTS - 1);

   slot_t wr_ptr_q, wr_ptr_d;
   slot_t rd_ptr_q, rd_ptr_d;
   slot_t cnt_q,    cnt_d;
   slot_t top_sel_q, top_sel_d;
   slot_t bot_sel_q, bot_sel_d;
   logic  ovf_q,    ovf_d;
   logic  full_q,   full_d;

   logic  commit;
   slot_t req;
   slot_t pop;

   pixel_t top_a [SLOTS];
   pixel_t top_b [SLOTS];
   pixel_t bot_a [SLOTS];
   pixel_t bot_b [SLOTS];

   // Two identical banks: when the bottom line replicates the top
   // line, four columns of one slot must be read in the same cycle.
   for (genvar s = 0; s < SLOTS; s++) begin : g_slot
      logic we;
      assign we = dInEn && (wr_ptr_q == slot_t'(s));

      line_ram u_top (
         .clk       (clk),
         .rst       (rst),
         .we        (we),
         .wr_addr   (ramAddrIn),
         .wr_data   (dIn),
         .rd_addr_a (ramRdAddr00),
         .rd_addr_b (ramRdAddr01),
         .rd_data_a (top_a[s]),
         .rd_data_b (top_b[s])
      );

      line_ram u_bot (
         .clk       (clk),
         .rst       (rst),
         .we        (we),
         .wr_addr   (ramAddrIn),
         .wr_data   (dIn),
         .rd_addr_a (ramRdAddr10),
         .rd_addr_b (ramRdAddr11),
         .rd_data_a (bot_a[s]),
         .rd_data_b (bot_b[s])
      );
   end

   always_comb begin
      commit = lineEnd && (cnt_q != FULL_CNT);

      if (jmp2) begin
         req = slot_t'(2);
      end else if (jmp1) begin
         req = slot_t'(1);
      end else begin
         req = '0;
      end

      // Never retire more lines than are committed.
      pop = (req > cnt_q) ? cnt_q : req;

      wr_ptr_d = wr_ptr_q + slot_t'(commit);
      rd_ptr_d = rd_ptr_q + pop;
      cnt_d    = cnt_q + slot_t'(commit) - pop;
      ovf_d    = ovf_q | (lineEnd & ~commit);

      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         ovf_d    = 1'b0;
      end

      full_d = (cnt_d == FULL_CNT);

      // Slot select travels with the addresses sampled this edge.
      top_sel_d = rd_ptr_q;
      if (cnt_q >= slot_t'(2)) begin
         bot_sel_d = rd_ptr_q + slot_t'(1);
      end else begin
         bot_sel_d = rd_ptr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         full_q    <= 1'b0;
         top_sel_q <= '0;
         bot_sel_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         full_q    <= full_d;
         top_sel_q <= top_sel_d;
         bot_sel_q <= bot_sel_d;
      end
   end

   always_comb begin
      ramData00 = top_a[top_sel_q];
      ramData01 = top_b[top_sel_q];
      ramData10 = bot_a[bot_sel_q];
      ramData11 = bot_b[bot_sel_q];
   end

   assign fifoNum = cnt_q;
   assign full    = full_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_ram_fifo.sv
// Directed bench for ram_fifo.
// Linear stimulus, immediate-assertion checks, one summary line.
module tb_ram_fifo;

   logic        clk = 1'b0;
   logic        rst, clr, dInEn, lineEnd, jmp1, jmp2;
   logic [15:0] dIn;
   logic [10:0] ramAddrIn;
   logic [10:0] ramRdAddr00, ramRdAddr01, ramRdAddr10, ramRdAddr11;
   logic [15:0] ramData00, ramData01, ramData10, ramData11;
   logic [1:0]  fifoNum;
   logic        full, ovf;

   int errors = 0;
   int checks = 0;

   ram_fifo dut (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr),
      .dIn         (dIn),
      .dInEn       (dInEn),
      .ramAddrIn   (ramAddrIn),
      .lineEnd     (lineEnd),
      .ramRdAddr00 (ramRdAddr00),
      .ramRdAddr01 (ramRdAddr01),
      .ramRdAddr10 (ramRdAddr10),
      .ramRdAddr11 (ramRdAddr11),
      .jmp1        (jmp1),
      .jmp2        (jmp2),
      .ramData00   (ramData00),
      .ramData01   (ramData01),
      .ramData10   (ramData10),
      .ramData11   (ramData11),
      .fifoNum     (fifoNum),
      .full        (full),
      .ovf         (ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic write_line(input logic [15:0] base, input bit fin);
      for (int c = 0; c < 8; c++) begin
         dInEn     = 1'b1;
         dIn       = base + 16'(c);
         ramAddrIn = 11'(c);
         tick();
      end
      dInEn = 1'b0;
      if (fin) begin
         lineEnd = 1'b1;
         tick();
         lineEnd = 1'b0;
      end
   endtask

   task automatic rd(input int a00, input int a01,
                     input int a10, input int a11);
      ramRdAddr00 = 11'(a00);
      ramRdAddr01 = 11'(a01);
      ramRdAddr10 = 11'(a10);
      ramRdAddr11 = 11'(a11);
      tick();
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; dInEn = 1'b0; lineEnd = 1'b0;
      jmp1 = 1'b0; jmp2 = 1'b0; dIn = '0; ramAddrIn = '0;
      ramRdAddr00 = '0; ramRdAddr01 = '0;
      ramRdAddr10 = '0; ramRdAddr11 = '0;
      tick();
      tick();
      chk("rst_d00", 32'(ramData00), 0);
      chk("rst_d01", 32'(ramData01), 0);
      chk("rst_d10", 32'(ramData10), 0);
      chk("rst_d11", 32'(ramData11), 0);
      chk("rst_num", 32'(fifoNum), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_ovf", 32'(ovf), 0);
      rst = 1'b0;

      // line A -> slot 0, single line: bottom replicates top
      write_line(16'h0000, 1'b1);
      chk("a_num", 32'(fifoNum), 1);
      rd(5, 0, 5, 1);
      chk("repl_d00", 32'(ramData00), 5);
      chk("repl_d10", 32'(ramData10), 5);
      chk("repl_d11", 32'(ramData11), 1);

      // line B -> slot 1, two lines: 2x2 neighbourhood
      write_line(16'h0100, 1'b1);
      chk("b_num", 32'(fifoNum), 2);
      rd(3, 4, 3, 4);
      chk("nb_d00", 32'(ramData00), 32'h003);
      chk("nb_d01", 32'(ramData01), 32'h004);
      chk("nb_d10", 32'(ramData10), 32'h103);
      chk("nb_d11", 32'(ramData11), 32'h104);

      // line C fills; line D overflows
      write_line(16'h0200, 1'b1);
      chk("c_num", 32'(fifoNum), 3);
      chk("c_full", 32'(full), 1);
      chk("c_ovf", 32'(ovf), 0);
      write_line(16'h0300, 1'b1);
      chk("d_num", 32'(fifoNum), 3);
      chk("d_full", 32'(full), 1);
      chk("d_ovf", 32'(ovf), 1);
      jmp1 = 1'b1;
      tick();
      jmp1 = 1'b0;
      chk("j1_num", 32'(fifoNum), 2);
      chk("j1_full", 32'(full), 0);
      chk("j1_ovf", 32'(ovf), 1);
      rd(3, 0, 3, 0);
      chk("j1_d00", 32'(ramData00), 32'h103);
      chk("j1_d10", 32'(ramData10), 32'h203);

      // line E -> slot 3, commit together with jmp2
      write_line(16'h0400, 1'b0);
      lineEnd = 1'b1;
      jmp2    = 1'b1;
      tick();
      lineEnd = 1'b0;
      jmp2    = 1'b0;
      chk("lj2_num", 32'(fifoNum), 1);
      rd(3, 0, 3, 0);
      chk("lj2_d00", 32'(ramData00), 32'h403);
      chk("lj2_d10", 32'(ramData10), 32'h403);

      // lines F (slot 0), G (slot 1); then jmp1+jmp2
      write_line(16'h0500, 1'b1);
      write_line(16'h0600, 1'b1);
      chk("fg_num", 32'(fifoNum), 3);
      jmp1 = 1'b1;
      jmp2 = 1'b1;
      tick();
      jmp1 = 1'b0;
      jmp2 = 1'b0;
      chk("both_num", 32'(fifoNum), 1);
      rd(2, 0, 0, 7);
      chk("both_d00", 32'(ramData00), 32'h602);
      chk("both_d11", 32'(ramData11), 32'h607);

      // saturate at zero, then flush with pending lineEnd
      jmp2 = 1'b1;
      tick();
      jmp2 = 1'b0;
      chk("sat_num", 32'(fifoNum), 0);
      chk("sat_ovf", 32'(ovf), 1);
      clr     = 1'b1;
      lineEnd = 1'b1;
      tick();
      clr     = 1'b0;
      lineEnd = 1'b0;
      chk("clr_num", 32'(fifoNum), 0);
      chk("clr_ovf", 32'(ovf), 0);
      chk("clr_full", 32'(full), 0);

      // after flush, writes and reads restart at slot 0
      write_line(16'h0700, 1'b1);
      chk("h_num", 32'(fifoNum), 1);
      rd(6, 0, 0, 0);
      chk("h_d00", 32'(ramData00), 32'h706);

      // reset mid-line discards partial line, clears outputs
      write_line(16'h0800, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_num", 32'(fifoNum), 0);
      chk("mrst_d00", 32'(ramData00), 0);
      chk("mrst_ovf", 32'(ovf), 0);
      lineEnd = 1'b1;
      tick();
      lineEnd = 1'b0;
      chk("mrst_le", 32'(fifoNum), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
